// File: rtl/audio_frame_reader.sv
`timescale 1ns/1ps
// audio_frame_reader
//
// Consumer end of the microphone sampler's frame interface. Holds `start`
// to arm the sampler and waits for the rising edge of its `done` level. On
// that edge it captures all FRAME_LEN parallel samples into a local frame
// buffer. It then streams the words one at a time over a valid/ready
// interface. The sampler is re-armed only after the last word is accepted.
//
// Ports
//   clk_25         25 MHz system clock; all registers use this clock
//   reset          synchronous, active-high reset
//   frame_done     sampler done level, already in the clk_25 domain
//   frame_data     packed samples, s0 in the least significant SAMPLE_W bits
//   start          capture request to the sampler (level)
//   out_valid      out_data holds a valid sample
//   out_ready      downstream accepts when high together with out_valid
//   out_data       current sample
//   out_index      position of out_data in the frame
//   out_last       high with out_valid on the final word of the frame
//   busy           high while the frame is being streamed
//   overrun_count  saturating count of frames that arrived while streaming
//
// Build option
//   AUDIO_FRAME_DC_REMOVE_EN  when defined, each sample has its MSB inverted
//                             at capture (offset binary -> two's complement)
//                             and out_data is declared signed.

module audio_frame_reader #(
  parameter int SAMPLE_W  = 18,
  parameter int FRAME_LEN = 16
) (
  input  logic                            clk_25,
  input  logic                            reset,
  input  logic                            frame_done,
  input  logic [SAMPLE_W*FRAME_LEN-1:0]   frame_data,
  output logic                            start,
  output logic                            out_valid,
  input  logic                            out_ready,
`ifdef AUDIO_FRAME_DC_REMOVE_EN
  output logic signed [SAMPLE_W-1:0]      out_data,
`else
  output logic [SAMPLE_W-1:0]             out_data,
`endif
  output logic [$clog2(FRAME_LEN)-1:0]    out_index,
  output logic                            out_last,
  output logic                            busy,
  output logic [7:0]                      overrun_count
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARM    = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  logic [1:0]          state;
  logic                done_q;
  logic [IDX_W-1:0]    idx;
  logic [SAMPLE_W-1:0] frame_buf [FRAME_LEN];

  logic done_rise;
  logic in_stream;
  logic fire;
  logic capture;

  // A done level held for many cycles yields a single rise.
  assign done_rise = frame_done & ~done_q;
  assign in_stream = (state == ST_STREAM);
  assign fire      = in_stream & out_ready;
  assign capture   = (state == ST_ARM) & done_rise;

  function automatic logic [SAMPLE_W-1:0] condition_sample(
    input logic [SAMPLE_W-1:0] raw
  );
`ifdef AUDIO_FRAME_DC_REMOVE_EN
    // Flipping the MSB subtracts midscale: 0x20000 -> 0, 0 -> -2^(W-1).
    condition_sample = {~raw[SAMPLE_W-1], raw[SAMPLE_W-2:0]};
`else
    condition_sample = raw;
`endif
  endfunction

  // Control: FSM, word index, done edge detector, overrun counter.
  always_ff @(posedge clk_25) begin
    if (reset) begin
      state         <= ST_IDLE;
      idx           <= '0;
      done_q        <= 1'b0;
      overrun_count <= '0;
    end else begin
      done_q <= frame_done;
      case (state)
        ST_IDLE: state <= ST_ARM;
        ST_ARM: begin
          if (done_rise) begin
            state <= ST_STREAM;
            idx   <= '0;
          end
        end
        ST_STREAM: begin
          if (fire) begin
            if (idx == LAST_IDX) state <= ST_ARM;
            else                 idx   <= idx + 1'b1;
          end
          // A frame arriving mid-stream, including on the last handshake,
          // is dropped and only counted.
          if (done_rise && (overrun_count != 8'hFF))
            overrun_count <= overrun_count + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Data: frame buffer is written only on capture and needs no reset.
  always_ff @(posedge clk_25) begin
    if (capture) begin
      for (int k = 0; k < FRAME_LEN; k++)
        frame_buf[k] <= condition_sample(frame_data[k*SAMPLE_W +: SAMPLE_W]);
    end
  end

  // Outputs decode from registered state only, so they cannot change while
  // a word is stalled, and read as zero outside STREAM.
  assign start     = (state == ST_ARM);
  assign busy      = in_stream;
  assign out_valid = in_stream;
  assign out_index = in_stream ? idx : '0;
  assign out_last  = in_stream && (idx == LAST_IDX);
  assign out_data  = in_stream ? frame_buf[idx] : '0;

endmodule

// File: tb/tb_audio_frame_reader.sv
`timescale 1ns/1ps
module tb_audio_frame_reader;

  localparam int SW = 18;
  localparam int FL = 16;

  logic              clk_25 = 1'b0;
  logic              reset;
  logic              frame_done;
  logic [SW*FL-1:0]  frame_data;
  logic              start;
  logic              out_valid;
  logic              out_ready;
  logic [SW-1:0]     out_data;
  logic [3:0]        out_index;
  logic              out_last;
  logic              busy;
  logic [7:0]        overrun_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [SW-1:0] exp_d [$];
  logic [3:0]    exp_i [$];

  audio_frame_reader #(.SAMPLE_W(SW), .FRAME_LEN(FL)) dut (
    .clk_25        (clk_25),
    .reset         (reset),
    .frame_done    (frame_done),
    .frame_data    (frame_data),
    .start         (start),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_index     (out_index),
    .out_last      (out_last),
    .busy          (busy),
    .overrun_count (overrun_count)
  );

  always #20 clk_25 = ~clk_25;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Expected streamed value for a raw captured sample.
  function automatic logic [SW-1:0] exp_of(input logic [SW-1:0] raw);
`ifdef AUDIO_FRAME_DC_REMOVE_EN
    exp_of = raw - 18'h20000;
`else
    exp_of = raw;
`endif
  endfunction

  task automatic tick;
    @(posedge clk_25);
    #1;
  endtask

  task automatic load_random_frame;
    logic [SW-1:0] v;
    for (int k = 0; k < FL; k++) begin
      v = SW'($urandom_range(0, 262143));
      frame_data[k*SW +: SW] = v;
      exp_d.push_back(exp_of(v));
      exp_i.push_back(4'(k));
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; frame_done = 1'b0; out_ready = 1'b0; frame_data = '0;
    repeat (3) begin
      tick;
      n_checks++;
      if ({start, out_valid, out_last, busy, out_data, out_index, overrun_count} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: got start=%b valid=%b last=%b busy=%b data=%h idx=%0d ovr=%0d, want all 0",
                 start, out_valid, out_last, busy, out_data, out_index, overrun_count);
      end
    end
    reset = 1'b0;
    n_checks++;
    if (start !== 1'b0) begin n_fail++; $display("FAIL idle_cycle_start: got %b want 0", start); end
    tick;
    n_checks++;
    if ({start, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL arm_after_reset: got start=%b valid=%b want 1 0", start, out_valid);
    end
  endtask

  // Called in the first ARM cycle after reset, so it also covers a rise there.
  task automatic test_full_frame;
    int got = 0;
    logic [SW-1:0] e; logic [3:0] ei;
    for (int k = 0; k < FL; k++) begin
      frame_data[k*SW +: SW] = SW'((k + 1) << 6);
      exp_d.push_back(exp_of(SW'((k + 1) << 6)));
      exp_i.push_back(4'(k));
    end
    frame_done = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      tick;
      if (cyc == 0) begin
        n_checks++;
        if ({out_valid, out_index, start} !== {1'b1, 4'd0, 1'b0}) begin
          n_fail++; $display("FAIL capture_latency: got valid=%b idx=%0d start=%b want 1 0 0", out_valid, out_index, start);
        end
      end
      if (out_valid) begin
        n_checks++;
        if (exp_d.size() == 0) begin
          n_fail++; $display("FAIL ff_word: unexpected word %h idx %0d", out_data, out_index);
        end else begin
          e = exp_d.pop_front(); ei = exp_i.pop_front();
          if ({out_data, out_index, out_last, start, busy} !== {e, ei, ei == 4'd15, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL ff_word: got data=%h idx=%0d last=%b start=%b busy=%b want data=%h idx=%0d",
                     out_data, out_index, out_last, start, busy, e, ei);
          end
        end
        got++;
      end
      if (cyc == 16) begin
        n_checks++;
        if ({start, out_valid} !== 2'b10) begin
          n_fail++; $display("FAIL ff_rearm: got start=%b valid=%b want 1 0", start, out_valid);
        end
      end
    end
    n_checks++;
    if (got != 16 || exp_d.size() != 0) begin
      n_fail++; $display("FAIL ff_one_frame: got %0d words, %0d left expected, want 16 and 0", got, exp_d.size());
    end
    frame_done = 1'b0;
    tick;
  endtask

  task automatic test_backpressure;
    int got = 0;
    bit stalled = 0;
    logic [SW-1:0] pd, e; logic [3:0] pi, ei;
    load_random_frame();
    frame_done = 1'b1; out_ready = 1'b0;
    tick;
    for (int cyc = 0; cyc < 100 && got < 16; cyc++) begin
      if (stalled) begin
        n_checks++;
        if ({out_data, out_index} !== {pd, pi}) begin
          n_fail++; $display("FAIL bp_hold: got data=%h idx=%0d want data=%h idx=%0d", out_data, out_index, pd, pi);
        end
      end
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_d.size() == 0) begin
          n_fail++; $display("FAIL bp_word: unexpected word %h", out_data);
        end else begin
          e = exp_d.pop_front(); ei = exp_i.pop_front();
          if ({out_data, out_index, out_last} !== {e, ei, ei == 4'd15}) begin
            n_fail++; $display("FAIL bp_word: got data=%h idx=%0d last=%b want data=%h idx=%0d", out_data, out_index, out_last, e, ei);
          end
        end
        got++; stalled = 0;
      end else if (out_valid) begin
        stalled = 1; pd = out_data; pi = out_index;
      end
      tick;
    end
    n_checks++;
    if (got != 16) begin n_fail++; $display("FAIL bp_count: got %0d words want 16", got); end
    frame_done = 1'b0; out_ready = 1'b1;
    tick;
  endtask

  task automatic test_overrun;
    int got = 0;
    logic [SW-1:0] e; logic [3:0] ei;
    load_random_frame();
    frame_done = 1'b1; out_ready = 1'b0;
    tick;
    frame_data = ~frame_data;
    repeat (2) begin
      frame_done = 1'b0; tick;
      frame_done = 1'b1; tick;
    end
    n_checks++;
    if ({overrun_count, out_index, out_valid} !== {8'd2, 4'd0, 1'b1}) begin
      n_fail++; $display("FAIL overrun_two: got count=%0d idx=%0d valid=%b want 2 0 1", overrun_count, out_index, out_valid);
    end
    frame_done = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && got < 16; cyc++) begin
      if (out_valid) begin
        if (out_index === 4'd15) frame_done = 1'b1;
        n_checks++;
        if (exp_d.size() == 0) begin
          n_fail++; $display("FAIL ovr_word: unexpected word %h", out_data);
        end else begin
          e = exp_d.pop_front(); ei = exp_i.pop_front();
          if ({out_data, out_index} !== {e, ei}) begin
            n_fail++; $display("FAIL ovr_word: got data=%h idx=%0d want data=%h idx=%0d", out_data, out_index, e, ei);
          end
        end
        got++;
      end
      tick;
    end
    n_checks++;
    if ({start, out_valid, overrun_count} !== {1'b1, 1'b0, 8'd3}) begin
      n_fail++; $display("FAIL overrun_on_last: got start=%b valid=%b count=%0d want 1 0 3", start, out_valid, overrun_count);
    end
    tick;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL no_capture_after_last: got valid=%b want 0", out_valid); end
    frame_done = 1'b0;
    tick;
  endtask

  task automatic test_overrun_saturate;
    int got = 0;
    logic [SW-1:0] e; logic [3:0] ei;
    load_random_frame();
    frame_done = 1'b1; out_ready = 1'b0;
    tick;
    repeat (300) begin
      frame_done = 1'b0; tick;
      frame_done = 1'b1; tick;
    end
    n_checks++;
    if (overrun_count !== 8'd255) begin n_fail++; $display("FAIL overrun_saturate: got %0d want 255", overrun_count); end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && got < 16; cyc++) begin
      if (out_valid) begin
        n_checks++;
        if (exp_d.size() == 0) begin
          n_fail++; $display("FAIL sat_word: unexpected word %h", out_data);
        end else begin
          e = exp_d.pop_front(); ei = exp_i.pop_front();
          if ({out_data, out_index} !== {e, ei}) begin
            n_fail++; $display("FAIL sat_word: got data=%h idx=%0d want data=%h idx=%0d", out_data, out_index, e, ei);
          end
        end
        got++;
      end
      tick;
    end
    frame_done = 1'b0;
    tick;
  endtask

  task automatic test_reset_midstream;
    int got = 0;
    logic [SW-1:0] e; logic [3:0] ei;
    load_random_frame();
    frame_done = 1'b1; out_ready = 1'b1;
    tick;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (out_valid && out_index === 4'd7) break;
      tick;
    end
    n_checks++;
    if (out_index !== 4'd7) begin n_fail++; $display("FAIL mid_reach7: got idx=%0d want 7", out_index); end
    reset = 1'b1; frame_done = 1'b0;
    tick;
    n_checks++;
    if ({out_valid, start, busy, overrun_count} !== '0) begin
      n_fail++; $display("FAIL mid_reset: got valid=%b start=%b busy=%b count=%0d want 0", out_valid, start, busy, overrun_count);
    end
    exp_d.delete(); exp_i.delete();
    reset = 1'b0;
    tick;
    n_checks++;
    if ({start, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL mid_rearm: got start=%b valid=%b want 1 0", start, out_valid);
    end
    load_random_frame();
    frame_done = 1'b1;
    tick;
    for (int cyc = 0; cyc < 20 && got < 16; cyc++) begin
      if (out_valid) begin
        n_checks++;
        if (exp_d.size() == 0) begin
          n_fail++; $display("FAIL mid_word: unexpected word %h", out_data);
        end else begin
          e = exp_d.pop_front(); ei = exp_i.pop_front();
          if ({out_data, out_index} !== {e, ei}) begin
            n_fail++; $display("FAIL mid_word: got data=%h idx=%0d want data=%h idx=%0d", out_data, out_index, e, ei);
          end
        end
        got++;
      end
      tick;
    end
    n_checks++;
    if (got != 16) begin n_fail++; $display("FAIL mid_count: got %0d words want 16", got); end
    frame_done = 1'b0;
    tick;
  endtask

  task automatic test_config;
    int got = 0;
    logic [SW-1:0] e; logic [3:0] ei;
    logic [SW-1:0] raw [3];
    logic [SW-1:0] want [3];
    raw[0] = 18'h20000; raw[1] = 18'h00000; raw[2] = 18'h3FFC0;
`ifdef AUDIO_FRAME_DC_REMOVE_EN
    want[0] = 18'h00000; want[1] = 18'h20000; want[2] = 18'h1FFC0;
`else
    want[0] = 18'h20000; want[1] = 18'h00000; want[2] = 18'h3FFC0;
`endif
    for (int k = 0; k < FL; k++) begin
      if (k < 3) begin
        frame_data[k*SW +: SW] = raw[k];
        exp_d.push_back(want[k]);
      end else begin
        frame_data[k*SW +: SW] = SW'(k << 6);
        exp_d.push_back(exp_of(SW'(k << 6)));
      end
      exp_i.push_back(4'(k));
    end
    frame_done = 1'b1; out_ready = 1'b1;
    tick;
    for (int cyc = 0; cyc < 20 && got < 16; cyc++) begin
      if (out_valid) begin
        n_checks++;
        if (exp_d.size() == 0) begin
          n_fail++; $display("FAIL cfg_word: unexpected word %h", out_data);
        end else begin
          e = exp_d.pop_front(); ei = exp_i.pop_front();
          if ({out_data, out_index} !== {e, ei}) begin
            n_fail++; $display("FAIL cfg_word: got data=%h idx=%0d want data=%h idx=%0d", out_data, out_index, e, ei);
          end
        end
        got++;
      end
      tick;
    end
    n_checks++;
    if (got != 16) begin n_fail++; $display("FAIL cfg_count: got %0d words want 16", got); end
    frame_done = 1'b0;
    tick;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_overrun();
    test_overrun_saturate();
    test_reset_midstream();
    test_config();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_frame_reader.md
# audio_frame_reader

Consumer end of the microphone sampler's frame interface. Arms the sampler by holding `start` and detects the rising edge of its `done` level. On that edge it latches the 16 parallel 18-bit samples into a local frame buffer. It then streams them one word at a time over a valid/ready interface to the downstream spectrum/visualizer pipeline, re-arming the sampler only after the whole frame has drained.

## Interface
- `SAMPLE_W`, 18, width of one sample word (ADC code << 6)
- `FRAME_LEN`, 16, samples per frame; `out_index` width is $clog2(FRAME_LEN)
- `clk_25`  in  1  25 MHz system clock; every register uses this clock
- `reset`  in  1  synchronous, active-high reset
- `frame_done`  in  1  sampler `done` level, already registered in `clk_25` domain
- `frame_data`  in  SAMPLE_W*FRAME_LEN  packed samples; s0 in [17:0], s1 in [35:18], … s15 in [287:270]
- `start`  out  1  capture request to sampler, level
- `out_valid`  out  1  `out_data` holds a valid sample
- `out_ready`  in  1  downstream accepts when high with `out_valid`
- `out_data`  out  SAMPLE_W  current sample
- `out_index`  out  4  position of `out_data` in frame (0..15)
- `out_last`  out  1  high with `out_valid` when `out_index` == FRAME_LEN-1
- `busy`  out  1  high in STREAM
- `overrun_count`  out  8  saturating count of ignored frames

## Operation
- The FSM has three states: IDLE, ARM and STREAM.
- **IDLE**
  - Entered on reset.
  - Moves to ARM unconditionally on the next cycle.
- **ARM**
  - `start`=1. Waits for `done_rise` = `frame_done` & ~`done_q`, where `done_q` is `frame_done` registered once.
  - On `done_rise`: latch `frame_data` into `buf[0..15]`, set `idx`=0, go to STREAM.
- **STREAM**
  - `start`=0, `busy`=1, `out_valid`=1, `out_data`=`buf[idx]`, `out_index`=`idx`.
  - On `out_valid` & `out_ready`:
    - If `idx`==15, go to ARM.
    - Otherwise `idx`++.
  - `done_rise` in STREAM does not touch `buf` or `idx`. It increments `overrun_count`, which saturates at 255.
- `out_data`, `out_index` and `out_last` are held stable while `out_valid` & ~`out_ready`.
- `done_rise` in IDLE is ignored and not counted.
- The sampler returns to its idle state once `start` drops after `done`, so no new frame is produced while streaming.
- `frame_done` held high across several cycles produces exactly one `done_rise`.

## Timing
- **Reset values:** `start`=0, `out_valid`=0, `out_data`=0, `out_index`=0, `out_last`=0, `busy`=0, `overrun_count`=0, `done_q`=0, state IDLE, `buf` don't-care.
- **Arming after reset:** reset released at cycle R means IDLE in R and ARM in R+1, so `start`=1 from R+1.
- **Capture latency:** `done_rise` seen in cycle N means `buf` is loaded at the end of N. In N+1, `out_valid`=1, `out_index`=0 and `start`=0.
- **Throughput:** with `out_ready` held high, the frame drains in 16 consecutive cycles (N+1..N+16). `out_last`=1 in N+16, and the FSM is back in ARM with `start`=1 in N+17.
- **Simultaneous events:**
  - A `done_rise` in the same cycle as the last handshake counts as an overrun and is not captured.
  - A `done_rise` in the first ARM cycle is captured.
- **Reset mid-stream:** the remaining words are dropped and `out_valid`=0 from the cycle after reset is sampled.

## Configuration
- `AUDIO_FRAME_DC_REMOVE_EN`
  - Defined: at capture, each sample has its MSB inverted, i.e. x − 2^(SAMPLE_W−1) in two's complement. Midscale 0x20000 becomes 0x00000, and `out_data` is signed.
  - Undefined: raw unsigned samples pass through unchanged.
  - Latency and handshake are identical in both builds.

## Test plan
- **Reset/arm:** assert `reset` 3 cycles, then release -> all outputs 0 during reset; `start`=1 exactly 1 cycle after release; `out_valid`=0.
- **Full frame, ready high:** sample k = (k+1)<<6, `frame_done` 0→1 held 40 cycles.
  - 16 outputs 0x40, 0x80 … 0x400 with `out_index` 0..15.
  - `out_last` only on 15; `start`=0 throughout; `start`=1 in the cycle after the last word.
  - Exactly one frame captured.
- **Backpressure:** `out_ready` toggles 1,0,0,1… -> no word skipped or duplicated; `out_data` constant while stalled; sequence matches the capture.
- **Overrun:** pulse `frame_done` low→high twice during STREAM -> `overrun_count`=2; the streamed data is still the first frame. 300 overruns -> `overrun_count`=255.
- **Reset mid-stream:** assert `reset` at `out_index`=7 -> `out_valid`=0 next cycle; after release the FSM re-arms and the next frame streams from index 0.
- **Configuration:** with `AUDIO_FRAME_DC_REMOVE_EN`, inputs 0x20000, 0x00000 and 0x3FFC0 -> outputs 0x00000, 0x20000 and 0x1FFC0. Without it, the outputs equal the inputs.
